// File: rtl/sdram_axi_arb.sv
// sdram_axi_arb: N-port request arbiter with burst lock and in-order response routing
module sdram_axi_arb #(
   parameter  int NUM_PORTS       = 2,
   parameter  int ADDR_W          = 32,
   parameter  int DATA_W          = 32,
   parameter  int MAX_OUTSTANDING = 4,
   parameter  int ARB_MODE        = 0,
   localparam int STRB_W          = DATA_W / 8,
   localparam int SW              = $clog2(NUM_PORTS),
   localparam int FW              = $clog2(MAX_OUTSTANDING)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_PORTS*STRB_W-1:0]   port_wr_i,
   input  logic [NUM_PORTS-1:0]          port_rd_i,
   input  logic [NUM_PORTS*8-1:0]        port_len_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]   port_write_data_i,
   output logic [NUM_PORTS-1:0]          port_accept_o,
   output logic [NUM_PORTS-1:0]          port_ack_o,
   output logic [NUM_PORTS-1:0]          port_error_o,
   output logic [DATA_W-1:0]             port_read_data_o,
   output logic [STRB_W-1:0]             ram_wr_o,
   output logic                          ram_rd_o,
   output logic [7:0]                    ram_len_o,
   output logic [ADDR_W-1:0]             ram_addr_o,
   output logic [DATA_W-1:0]             ram_write_data_o,
   input  logic                          ram_accept_i,
   input  logic                          ram_ack_i,
   input  logic                          ram_error_i,
   input  logic [DATA_W-1:0]             ram_read_data_i,
   output logic [FW:0]                   outstanding_o,
   output logic                          spurious_ack_o
);
   logic [NUM_PORTS-1:0] req;
   logic [SW-1:0]        tags [MAX_OUTSTANDING];
   logic [FW-1:0]        wr_ptr, rd_ptr;
   logic [SW-1:0]        rr_ptr, lock_port, arb_sel, sel;
   logic [7:0]           beat_cnt;
   logic                 locked, arb_hit, fwd, accept, pop, full;
   int                   idx;

   // a port requests when any write strobe or its read flag is set
   always_comb begin
      req = '0;
      for (int p = 0; p < NUM_PORTS; p++) req[p] = |port_wr_i[p*STRB_W +: STRB_W] | port_rd_i[p];
   end

   // scan downward so the lowest offset from the start point wins
   always_comb begin
      arb_hit = 1'b0;
      arb_sel = '0;
      idx     = 0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         idx = ARB_MODE != 0 ? i : (int'(rr_ptr) + i) % NUM_PORTS;
         if (req[idx]) begin
            arb_hit = 1'b1;
            arb_sel = SW'(idx);
         end
      end
   end

   assign full             = outstanding_o == (FW+1)'(MAX_OUTSTANDING);
   assign sel              = locked ? lock_port : arb_sel;
   assign fwd              = ~full & (locked ? req[lock_port] : arb_hit);
   assign accept           = fwd & ram_accept_i;
   assign pop              = ram_ack_i & (outstanding_o != '0);
   assign ram_wr_o         = fwd ? port_wr_i[sel*STRB_W +: STRB_W] : '0;
   assign ram_rd_o         = fwd & port_rd_i[sel];
   assign ram_len_o        = port_len_i[sel*8 +: 8];
   assign ram_addr_o       = port_addr_i[sel*ADDR_W +: ADDR_W];
   assign ram_write_data_o = port_write_data_i[sel*DATA_W +: DATA_W];
   assign port_accept_o    = accept ? NUM_PORTS'(1) << sel : '0;
   assign port_ack_o       = pop ? NUM_PORTS'(1) << tags[rd_ptr] : '0;
   assign port_error_o     = ram_error_i ? port_ack_o : '0;
   assign port_read_data_o = pop ? ram_read_data_i : '0;

   // tag FIFO, burst lock, round-robin pointer and sticky spurious-ack flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         outstanding_o  <= '0;
         locked         <= 1'b0;
         lock_port      <= '0;
         beat_cnt       <= '0;
         rr_ptr         <= '0;
         spurious_ack_o <= 1'b0;
      end else begin
         if (accept) begin
            tags[wr_ptr] <= sel;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         outstanding_o <= outstanding_o + (FW+1)'(accept) - (FW+1)'(pop);
         if (ram_ack_i && outstanding_o == '0) spurious_ack_o <= 1'b1;
         if (accept && !locked) begin
            rr_ptr <= sel == SW'(NUM_PORTS - 1) ? '0 : sel + 1'b1;
            if (ram_len_o != 8'd0) begin
               locked    <= 1'b1;
               lock_port <= sel;
               beat_cnt  <= ram_len_o;
            end
         end else if (accept) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd1) locked <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sdram_axi_arb.sv
// tb_sdram_axi_arb: random traffic on a round-robin and a fixed-priority arbiter against a queue-based model
module tb_sdram_axi_arb;
   localparam int NP = 3, AW = 32, DW = 32, SB = DW / 8, MO = 4, OW = $clog2(MO) + 1;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic [1:0][NP*SB-1:0] p_wr;
   logic [1:0][NP-1:0]    p_rd, p_acc, p_ack, p_err;
   logic [1:0][NP*8-1:0]  p_len;
   logic [1:0][NP*AW-1:0] p_addr;
   logic [1:0][NP*DW-1:0] p_wdata;
   logic [1:0][DW-1:0]    p_rdata, r_wdata, r_rdata;
   logic [1:0][SB-1:0]    r_wr;
   logic [1:0][7:0]       r_len;
   logic [1:0][AW-1:0]    r_addr;
   logic [1:0][OW-1:0]    outst;
   logic [1:0]            r_rd, r_acc, r_ack, r_err, spur;
   int checks = 0, errors = 0;
   int tq [2][$];
   int lk [2], rem [2], rr [2];
   bit sp [2];
   bit pend [2][NP];
   logic [NP-1:0] acc_m [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sdram_axi_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .ARB_MODE(g)) dut (
         .clk_i(clk), .rst_ni(rst_n),
         .port_wr_i(p_wr[g]), .port_rd_i(p_rd[g]), .port_len_i(p_len[g]), .port_addr_i(p_addr[g]),
         .port_write_data_i(p_wdata[g]), .port_accept_o(p_acc[g]), .port_ack_o(p_ack[g]),
         .port_error_o(p_err[g]), .port_read_data_o(p_rdata[g]),
         .ram_wr_o(r_wr[g]), .ram_rd_o(r_rd[g]), .ram_len_o(r_len[g]), .ram_addr_o(r_addr[g]),
         .ram_write_data_o(r_wdata[g]), .ram_accept_i(r_acc[g]), .ram_ack_i(r_ack[g]),
         .ram_error_i(r_err[g]), .ram_read_data_i(r_rdata[g]),
         .outstanding_o(outst[g]), .spurious_ack_o(spur[g]));
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int m);
      int sel, s, p, n;
      bit acc, pop;
      logic [NP-1:0] req, e_ack;
      n = tq[m].size();
      for (int k = 0; k < NP; k++) req[k] = (p_wr[m][k*SB +: SB] != '0) || p_rd[m][k];
      sel = -1;
      if (n < MO) begin
         if (lk[m] >= 0) begin
            if (req[lk[m]]) sel = lk[m];
         end else
            for (int k = 0; k < NP; k++) begin
               p = m == 1 ? k : (rr[m] + k) % NP;
               if (sel < 0 && req[p]) sel = p;
            end
      end
      s = sel < 0 ? 0 : sel;
      acc = sel >= 0 && r_acc[m];
      pop = r_ack[m] && n > 0;
      e_ack = pop ? NP'(1) << tq[m][0] : '0;
      check($sformatf("ram_wr[%0d]", m), 64'(r_wr[m]), sel >= 0 ? 64'(p_wr[m][s*SB +: SB]) : 64'd0);
      check($sformatf("ram_rd[%0d]", m), 64'(r_rd[m]), sel >= 0 ? 64'(p_rd[m][s]) : 64'd0);
      if (sel >= 0) begin
         check($sformatf("ram_len[%0d]", m), 64'(r_len[m]), 64'(p_len[m][s*8 +: 8]));
         check($sformatf("ram_addr[%0d]", m), 64'(r_addr[m]), 64'(p_addr[m][s*AW +: AW]));
         check($sformatf("ram_wdata[%0d]", m), 64'(r_wdata[m]), 64'(p_wdata[m][s*DW +: DW]));
      end
      check($sformatf("accept[%0d]", m), 64'(p_acc[m]), acc ? 64'(NP'(1) << sel) : 64'd0);
      check($sformatf("ack[%0d]", m), 64'(p_ack[m]), 64'(e_ack));
      check($sformatf("error[%0d]", m), 64'(p_err[m]), r_err[m] ? 64'(e_ack) : 64'd0);
      if (pop) check($sformatf("rdata[%0d]", m), 64'(p_rdata[m]), 64'(r_rdata[m]));
      check($sformatf("outstanding[%0d]", m), 64'(outst[m]), 64'(n));
      check($sformatf("spurious[%0d]", m), 64'(spur[m]), 64'(sp[m]));
      acc_m[m] = acc ? NP'(1) << sel : '0;
      if (!rst_n) begin
         tq[m].delete();
         lk[m] = -1;
         rem[m] = 0;
         rr[m] = 0;
         sp[m] = 1'b0;
      end else begin
         if (r_ack[m] && n == 0) sp[m] = 1'b1;
         if (pop) void'(tq[m].pop_front());
         if (acc) begin
            tq[m].push_back(sel);
            if (lk[m] < 0) begin
               rr[m] = (sel + 1) % NP;
               if (p_len[m][sel*8 +: 8] != 8'd0) begin
                  lk[m] = sel;
                  rem[m] = int'(p_len[m][sel*8 +: 8]);
               end
            end else begin
               rem[m]--;
               if (rem[m] == 0) lk[m] = -1;
            end
         end
      end
   endtask

   task automatic drive(input int m, input bit idle, input bit force_ack, input int ackp);
      for (int p = 0; p < NP; p++) begin
         if (acc_m[m][p] || idle) pend[m][p] = 1'b0;
         if (!pend[m][p]) begin
            p_wr[m][p*SB +: SB] = '0;
            p_rd[m][p] = 1'b0;
            if (!idle && $urandom_range(99) < (lk[m] == p ? 75 : 35)) begin
               pend[m][p] = 1'b1;
               if ($urandom_range(1) == 1) p_wr[m][p*SB +: SB] = SB'($urandom_range(15, 1));
               else p_rd[m][p] = 1'b1;
               p_len[m][p*8 +: 8] = $urandom_range(2) == 0 ? 8'($urandom_range(3, 1)) : 8'd0;
               p_addr[m][p*AW +: AW] = AW'($urandom);
               p_wdata[m][p*DW +: DW] = DW'($urandom);
            end
         end
      end
      r_acc[m] = !idle && $urandom_range(3) != 0;
      r_ack[m] = force_ack || (!idle && tq[m].size() > 0 && $urandom_range(99) < ackp);
      r_err[m] = $urandom_range(3) == 0;
      r_rdata[m] = DW'($urandom);
   endtask

   initial begin
      bit fired [3];
      bit last_rst;
      p_wr = '0; p_rd = '0; p_len = '0; p_addr = '0; p_wdata = '0;
      r_acc = '0; r_ack = '0; r_err = '0; r_rdata = '0;
      for (int m = 0; m < 2; m++) begin
         lk[m] = -1; rem[m] = 0; rr[m] = 0; sp[m] = 1'b0; acc_m[m] = '0;
         for (int p = 0; p < NP; p++) pend[m][p] = 1'b0;
      end
      for (int w = 0; w < 3; w++) fired[w] = 1'b0;
      last_rst = 1'b0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         if (cyc < 2) rst_n = 1'b0;
         else if (cyc % 400 >= 100 && cyc % 400 <= 200 && !fired[cyc/400] &&
                  ((lk[0] >= 0 && tq[0].size() >= 2) || cyc % 400 == 200)) begin
            rst_n = 1'b0;
            fired[cyc/400] = 1'b1;
         end
         for (int m = 0; m < 2; m++) drive(m, cyc < 2, last_rst && cyc >= 2, cyc % 400 < 250 ? 50 : 10);
         last_rst = !rst_n;
         @(negedge clk);
         step(0);
         step(1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
